ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Alternates grants on ties, never re-issues the request it is currently
// granting, and returns read data to the owning requester two cycles after
// its grant through a small owner-tag pipeline.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_s2_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;   // 0 = requester 0 was granted last
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic                  r_ram_we;

  // Owner-tag pipeline: stage 1 aligns with the grant cycle, stage 2 with
  // the cycle the RAM presents its read data.
  logic                  r_tag1_v;
  logic                  r_tag1_own;
  logic                  r_tag2_v;
  logic                  r_tag2_own;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_elig0;
  logic                  w_elig1;
  state_t                w_next;
  logic                  w_read_issue;

  // Arbitration: pick the next grant from eligible requesters.
  always_comb begin
    w_elig0      = req0 && (r_state != S_GNT0);
    w_elig1      = req1 && (r_state != S_GNT1);
    w_next       = S_IDLE;
    w_read_issue = 1'b0;
    if (w_elig0 && w_elig1) begin
      // Tie: the requester that was not granted last wins.
      w_next = r_last_grant ? S_GNT0 : S_GNT1;
    end else if (w_elig0) begin
      w_next = S_GNT0;
    end else if (w_elig1) begin
      w_next = S_GNT1;
    end else begin
      w_next = S_IDLE;
    end
    case (w_next)
      S_GNT0:  w_read_issue = !we0;
      S_GNT1:  w_read_issue = !we1;
      default: w_read_issue = 1'b0;
    endcase
  end

  // Grant FSM with registered grant pulses and RAM drive.
  always_ff @(posedge clock) begin
    if (!reset_s2_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
      r_ram_we      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (w_next)
        S_GNT0: begin
          r_gnt0        <= 1'b1;
          r_gnt1        <= 1'b0;
          r_last_grant  <= 1'b0;
          r_ram_address <= addr0;
          r_ram_data_in <= wdata0;
          r_ram_we      <= we0;
        end
        S_GNT1: begin
          r_gnt0        <= 1'b0;
          r_gnt1        <= 1'b1;
          r_last_grant  <= 1'b1;
          r_ram_address <= addr1;
          r_ram_data_in <= wdata1;
          r_ram_we      <= we1;
        end
        default: begin
          // Idle: address and write data hold, write strobe drops.
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Read-return path: track read owners and capture RAM data for them.
  always_ff @(posedge clock) begin
    if (!reset_s2_n) begin
      r_tag1_v   <= 1'b0;
      r_tag1_own <= 1'b0;
      r_tag2_v   <= 1'b0;
      r_tag2_own <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_tag1_v   <= w_read_issue;
      r_tag1_own <= (w_next == S_GNT1);
      r_tag2_v   <= r_tag1_v;
      r_tag2_own <= r_tag1_own;
      r_rvalid0  <= r_tag2_v && !r_tag2_own;
      r_rvalid1  <= r_tag2_v && r_tag2_own;
      if (r_tag2_v && !r_tag2_own) begin
        r_rdata0 <= ram_data_out;
      end
      if (r_tag2_v && r_tag2_own) begin
        r_rdata1 <= ram_data_out;
      end
    end
  end

  assign gnt0             = r_gnt0;
  assign gnt1             = r_gnt1;
  assign rvalid0          = r_rvalid0;
  assign rvalid1          = r_rvalid1;
  assign rdata0           = r_rdata0;
  assign rdata1           = r_rdata1;
  assign ram_address      = r_ram_address;
  assign ram_data_in      = r_ram_data_in;
  assign ram_write_enable = r_ram_we;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset_s2_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_write_enable;
  logic [7:0] rdata0, rdata1, ram_address, ram_data_in;
  logic [7:0] ram_data_out = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0]   mem [256];
  logic [255:0] written = '0;

  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset_s2_n(reset_s2_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // Initial RAM contents for locations never written.
  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      8'h03:   return 8'h33;
      8'h04:   return 8'h44;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  // Single-port synchronous RAM: read data valid the cycle after the address.
  always @(posedge clock) begin
    if (ram_write_enable) begin
      mem[ram_address]     <= ram_data_in;
      written[ram_address] <= 1'b1;
    end
    ram_data_out <= written[ram_address] ? mem[ram_address] : init_val(ram_address);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_s2_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick();
    tick();
    reset_s2_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, ram_write_enable} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, ram_write_enable}); end
    checks++; if ({ram_address, ram_data_in, rdata0, rdata1} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", {ram_address, ram_data_in, rdata0, rdata1}); end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    checks++; if ({gnt0, gnt1, ram_write_enable} !== 3'b100) begin
      errors++; $display("FAIL rd_gnt: got %b expected 100", {gnt0, gnt1, ram_write_enable}); end
    checks++; if (ram_address !== 8'h10) begin
      errors++; $display("FAIL rd_addr: got %h expected 10", ram_address); end
    req0 = 1'b0;
    tick();
    checks++; if ({gnt0, rvalid0} !== 2'b00 || ram_address !== 8'h10) begin
      errors++; $display("FAIL rd_idle_hold: got gnt0/rvalid0 %b addr %h expected 00 10", {gnt0, rvalid0}, ram_address); end
    tick();
    checks++; if ({rvalid0, rvalid1} !== 2'b10 || rdata0 !== 8'hA5) begin
      errors++; $display("FAIL rd_return: got rvalid %b rdata0 %h expected 10 a5", {rvalid0, rvalid1}, rdata0); end
    tick();
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 8'hA5) begin
      errors++; $display("FAIL rd_hold: got rvalid0 %b rdata0 %h expected 0 a5", rvalid0, rdata0); end
  endtask

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
    tick();
    checks++; if ({gnt0, gnt1, ram_write_enable} !== 3'b011 || ram_address !== 8'h20 || ram_data_in !== 8'h3C) begin
      errors++; $display("FAIL wr_issue: got %b addr %h din %h expected 011 20 3c", {gnt0, gnt1, ram_write_enable}, ram_address, ram_data_in); end
    we1 = 1'b0;
    tick();
    checks++; if ({gnt1, ram_write_enable} !== 2'b00) begin
      errors++; $display("FAIL wr_gap: got %b expected 00", {gnt1, ram_write_enable}); end
    tick();
    checks++; if ({gnt1, ram_write_enable, rvalid1} !== 3'b100) begin
      errors++; $display("FAIL rd1_issue: got %b expected 100", {gnt1, ram_write_enable, rvalid1}); end
    req1 = 1'b0;
    tick();
    tick();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C || rvalid0 !== 1'b0) begin
      errors++; $display("FAIL rd1_return: got rvalid1 %b rdata1 %h rvalid0 %b expected 1 3c 0", rvalid1, rdata1, rvalid0); end
    tick();
  endtask

  task automatic test_tie();
    logic exp0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    reset_s2_n = 1'b0;
    tick();
    reset_s2_n = 1'b1;
    checks++; if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL tie_first_cycle: got %b expected 00", {gnt0, gnt1}); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp0 = (i % 2 == 0);
      checks++; if ({gnt0, gnt1} !== {exp0, !exp0}) begin
        errors++; $display("FAIL tie_order[%0d]: got %b expected %b", i, {gnt0, gnt1}, {exp0, !exp0}); end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ((rvalid0 && rvalid1) || (gnt0 && gnt1)) begin
        errors++; $display("FAIL tie_exclusive[%0d]: got rvalid %b gnt %b expected one-hot or zero", i, {rvalid0, rvalid1}, {gnt0, gnt1}); end
    end
  endtask

  task automatic test_stream();
    logic [7:0] sd [4];
    sd = '{8'h11, 8'h22, 8'h33, 8'h44};
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (gnt0 !== 1'b1 || ram_address !== 8'(i + 1)) begin
        errors++; $display("FAIL stream_gnt[%0d]: got gnt0 %b addr %h expected 1 %h", i, gnt0, ram_address, 8'(i + 1)); end
      if (i > 0) begin
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== sd[i-1]) begin
          errors++; $display("FAIL stream_data[%0d]: got rvalid0 %b rdata0 %h expected 1 %h", i - 1, rvalid0, rdata0, sd[i-1]); end
      end
      if (i == 3) req0 = 1'b0;
      else addr0 = 8'(i + 2);
      tick();
      checks++; if ({gnt0, rvalid0} !== 2'b00) begin
        errors++; $display("FAIL stream_gap[%0d]: got %b expected 00", i, {gnt0, rvalid0}); end
    end
    tick();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h44) begin
      errors++; $display("FAIL stream_last: got rvalid0 %b rdata0 %h expected 1 44", rvalid0, rdata0); end
    tick();
  endtask

  task automatic test_withdraw();
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h04;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL wd_gnt: got %b expected 10", {gnt0, gnt1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL wd_no_gnt1: got %b expected 00", {gnt0, gnt1}); end
    tick();
    checks++; if ({rvalid0, rvalid1} !== 2'b10 || rdata0 !== 8'h33) begin
      errors++; $display("FAIL wd_return: got %b rdata0 %h expected 10 33", {rvalid0, rvalid1}, rdata0); end
    tick();
    checks++; if ({gnt1, rvalid1} !== 2'b00) begin
      errors++; $display("FAIL wd_no_rvalid1: got %b expected 00", {gnt1, rvalid1}); end
  endtask

  task automatic test_reset_mid_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    checks++; if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: got %b expected 1", gnt0); end
    req0 = 1'b0;
    tick();
    reset_s2_n = 1'b0;
    tick();
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, ram_write_enable} !== 5'b0) begin
      errors++; $display("FAIL mid_ctrl: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, ram_write_enable}); end
    checks++; if ({ram_address, ram_data_in, rdata0, rdata1} !== 32'h0) begin
      errors++; $display("FAIL mid_data: got %h expected 00000000", {ram_address, ram_data_in, rdata0, rdata1}); end
    reset_s2_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({rvalid0, rvalid1} !== 2'b00) begin
        errors++; $display("FAIL mid_discard[%0d]: got %b expected 00", i, {rvalid0, rvalid1}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_stream();
    test_withdraw();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
